// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of the byte-addressed
// data memory. Port 0 is the load/store unit and port 1 a secondary master.
// A winning command is registered in IDLE, driven to memory for one cycle in
// ISSUE, and acknowledged for one cycle in RESP. Misaligned and illegal-mode
// accesses are flagged when latched and never write the memory.
// Build option ARB_ROUND_ROBIN_EN: defined selects round-robin arbitration,
// undefined selects fixed priority with port 0 winning simultaneous requests.
module dmem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [2:0]       p0_mode,
  input  logic [WIDTH-1:0] p0_addr,
  input  logic [WIDTH-1:0] p0_wdata,
  output logic             p0_ack,
  output logic             p0_err,
  output logic [WIDTH-1:0] p0_rdata,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [2:0]       p1_mode,
  input  logic [WIDTH-1:0] p1_addr,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic             p1_ack,
  output logic             p1_err,
  output logic [WIDTH-1:0] p1_rdata,
  output logic [2:0]       mem_modeAddr,
  output logic [WIDTH-1:0] mem_A,
  output logic [WIDTH-1:0] mem_WD,
  output logic             mem_WE,
  input  logic [WIDTH-1:0] mem_RD,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               cmd_we_q, cmd_we_d;
  logic [2:0]         cmd_mode_q, cmd_mode_d;
  logic [WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic               cmd_port_q, cmd_port_d;
  logic               cmd_err_q, cmd_err_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;

  logic               grant_valid;
  logic               grant_port;
  logic               sel_we;
  logic [2:0]         sel_mode;
  logic [WIDTH-1:0]   sel_addr;
  logic [WIDTH-1:0]   sel_wdata;

  // An access is rejected for an unknown mode or a misaligned word/half address.
  function automatic logic access_error(input logic [2:0] mode, input logic [1:0] addr_lo);
    logic err;
    err = 1'b1;
    case (mode)
      3'b001:         err = (addr_lo != 2'b00);
      3'b010, 3'b100: err = addr_lo[0];
      3'b011, 3'b101: err = 1'b0;
      default:        err = 1'b1;
    endcase
    return err;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  // Last-served port; reset value means port 0 was served last.
  logic last_q, last_d;

  // Pointer follows the winner only when a command is actually latched.
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && grant_valid) begin
      last_d = grant_port;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Pick the winning port and steer its command fields.
  always_comb begin
    grant_valid = p0_req | p1_req;
    grant_port  = 1'b0;
    if (p0_req && p1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_port = ~last_q;
`else
      grant_port = 1'b0;
`endif
    end else if (p1_req) begin
      grant_port = 1'b1;
    end
    sel_we    = grant_port ? p1_we    : p0_we;
    sel_mode  = grant_port ? p1_mode  : p0_mode;
    sel_addr  = grant_port ? p1_addr  : p0_addr;
    sel_wdata = grant_port ? p1_wdata : p0_wdata;
  end

  // Sequencer next-state: latch in IDLE, capture read data in ISSUE, ack in RESP.
  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_mode_d  = cmd_mode_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_port_d  = cmd_port_q;
    cmd_err_d   = cmd_err_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          cmd_we_d    = sel_we;
          cmd_mode_d  = sel_mode;
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = sel_wdata;
          cmd_port_d  = grant_port;
          cmd_err_d   = access_error(sel_mode, sel_addr[1:0]);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        rdata_d = (cmd_we_q || cmd_err_q) ? '0 : mem_RD;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, command register and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_we_q    <= 1'b0;
      cmd_mode_q  <= 3'b000;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_port_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_mode_q  <= cmd_mode_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_port_q  <= cmd_port_d;
      cmd_err_q   <= cmd_err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Memory and port outputs decoded from state so reset kills them instantly.
  always_comb begin
    mem_A        = cmd_addr_q;
    mem_WD       = cmd_wdata_q;
    mem_modeAddr = cmd_mode_q;
    mem_WE       = (state_q == ISSUE) && cmd_we_q && !cmd_err_q;
    busy         = (state_q != IDLE);
    p0_ack       = (state_q == RESP) && !cmd_port_q;
    p1_ack       = (state_q == RESP) &&  cmd_port_q;
    p0_err       = p0_ack && cmd_err_q;
    p1_err       = p1_ack && cmd_err_q;
    p0_rdata     = p0_ack ? rdata_q : '0;
    p1_rdata     = p1_ack ? rdata_q : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: byte-array memory model, per-port scoreboards of
// expected acknowledges, and directed transactions.
module tb_dmem_arbiter;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int port;
    int cyc;
  } ack_t;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [2:0]  p0_mode, p1_mode;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [2:0]  mem_modeAddr;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;
  logic        busy;

  logic [7:0]  mem [0:4095];
  logic [11:0] ri;
  logic [7:0]  b0, b1, b2, b3;

  exp_t q0[$];
  exp_t q1[$];
  ack_t ack_log[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;
  int we_cnt = 0;

  dmem_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_mode(p0_mode), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_mode(p1_mode), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_modeAddr(mem_modeAddr), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
    .mem_RD(mem_RD), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every vector and reports a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Memory model: little-endian bytes, mode-sized writes, sign/zero-extended reads.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_WE) begin
      case (mem_modeAddr)
        3'b001: begin
          mem[mem_A[11:0]]         = mem_WD[7:0];
          mem[mem_A[11:0] + 12'd1] = mem_WD[15:8];
          mem[mem_A[11:0] + 12'd2] = mem_WD[23:16];
          mem[mem_A[11:0] + 12'd3] = mem_WD[31:24];
        end
        3'b010, 3'b100: begin
          mem[mem_A[11:0]]         = mem_WD[7:0];
          mem[mem_A[11:0] + 12'd1] = mem_WD[15:8];
        end
        3'b011, 3'b101: mem[mem_A[11:0]] = mem_WD[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    ri = mem_A[11:0];
    b0 = mem[ri];
    b1 = mem[ri + 12'd1];
    b2 = mem[ri + 12'd2];
    b3 = mem[ri + 12'd3];
    case (mem_modeAddr)
      3'b001:  mem_RD = {b3, b2, b1, b0};
      3'b010:  mem_RD = {{16{b1[7]}}, b1, b0};
      3'b011:  mem_RD = {{24{b0[7]}}, b0};
      3'b100:  mem_RD = {16'h0000, b1, b0};
      3'b101:  mem_RD = {24'h000000, b0};
      default: mem_RD = 32'h0;
    endcase
  end

  function automatic logic [31:0] memWord(input logic [11:0] i);
    return {mem[i + 12'd3], mem[i + 12'd2], mem[i + 12'd1], mem[i]};
  endfunction

  function automatic int ackCount(input int port);
    return (port == 0) ? ack_cnt0 : ack_cnt1;
  endfunction

  // Scoreboard side: pop the expected result for each ack and check idle ports.
  always @(negedge clk) begin
    exp_t e;
    ack_t a;
    if (rst_n) begin
      if (mem_WE) we_cnt++;
      checkOutput("ack_exclusive", {31'b0, p0_ack & p1_ack}, 32'h0);
      if (p0_ack) begin
        if (q0.size() == 0) begin
          checkOutput("p0_unexpected_ack", 32'h1, 32'h0);
        end else begin
          e = q0.pop_front();
          checkOutput("p0_err", {31'b0, p0_err}, {31'b0, e.err});
          checkOutput("p0_rdata", p0_rdata, e.rdata);
        end
        a.port = 0; a.cyc = cyc; ack_log.push_back(a);
        ack_cnt0++;
      end else begin
        checkOutput("p0_idle_err", {31'b0, p0_err}, 32'h0);
        checkOutput("p0_idle_rdata", p0_rdata, 32'h0);
      end
      if (p1_ack) begin
        if (q1.size() == 0) begin
          checkOutput("p1_unexpected_ack", 32'h1, 32'h0);
        end else begin
          e = q1.pop_front();
          checkOutput("p1_err", {31'b0, p1_err}, {31'b0, e.err});
          checkOutput("p1_rdata", p1_rdata, e.rdata);
        end
        a.port = 1; a.cyc = cyc; ack_log.push_back(a);
        ack_cnt1++;
      end else begin
        checkOutput("p1_idle_err", {31'b0, p1_err}, 32'h0);
        checkOutput("p1_idle_rdata", p1_rdata, 32'h0);
      end
    end
  end

  // All DUT outputs must read zero after reset and before any new request.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags"}, {26'b0, p0_ack, p1_ack, p0_err, p1_err, busy, mem_WE}, 32'h0);
    checkOutput({tag, "_rdata"}, p0_rdata | p1_rdata, 32'h0);
    checkOutput({tag, "_mem_A"}, mem_A, 32'h0);
    checkOutput({tag, "_mem_WD"}, mem_WD, 32'h0);
    checkOutput({tag, "_mem_mode"}, {29'b0, mem_modeAddr}, 32'h0);
  endtask

  // One complete transaction on one port, starting and ending in IDLE.
  task automatic applyStimulus(input int port, input logic we, input logic [2:0] mode,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] exp_rdata,
                               input int exp_we, input string tag);
    exp_t e;
    int start, n0, w0;
    e.err = exp_err;
    e.rdata = exp_rdata;
    n0 = ackCount(port);
    if (port == 0) begin
      q0.push_back(e);
      p0_we = we; p0_mode = mode; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      q1.push_back(e);
      p1_we = we; p1_mode = mode; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end
    start = cyc;
    w0 = we_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (ackCount(port) != n0) break;
    end
    checkOutput({tag, "_latency"}, cyc - start, 32'd2);
    checkOutput({tag, "_we_pulses"}, we_cnt - w0, exp_we);
    if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int n0, start, first, second;
    rst_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_mode = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_mode = 0; p1_addr = 0; p1_wdata = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    checkAllZero("reset");

    $display("[TB] store then load word on port 0");
    applyStimulus(0, 1'b1, 3'b001, 32'h0001_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1, "p0_sw");
    checkOutput("mem_after_sw", memWord(12'h010), 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 3'b001, 32'h0001_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 0, "p0_lw");

    $display("[TB] seed words for the dual-port run");
    applyStimulus(0, 1'b1, 3'b001, 32'h0001_0040, 32'h1111_2222, 1'b0, 32'h0, 1, "p0_seed");
    applyStimulus(1, 1'b1, 3'b001, 32'h0001_0080, 32'h3333_4444, 1'b0, 32'h0, 1, "p1_seed");

    $display("[TB] both ports loading continuously");
    e.err = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) begin
      e.rdata = 32'h1111_2222; q0.push_back(e);
      e.rdata = 32'h3333_4444; q1.push_back(e);
    end
`else
    for (int k = 0; k < 6; k++) begin
      e.rdata = 32'h1111_2222; q0.push_back(e);
    end
`endif
    ack_log.delete();
    p0_we = 0; p0_mode = 3'b001; p0_addr = 32'h0001_0040;
    p1_we = 0; p1_mode = 3'b001; p1_addr = 32'h0001_0080;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (ack_log.size() >= 6) break;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    checkOutput("dual_ack_count", ack_log.size(), 32'd6);
    for (int k = 0; k < ack_log.size() && k < 6; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      checkOutput("dual_grant", ack_log[k].port, k % 2);
`else
      checkOutput("dual_grant", ack_log[k].port, 32'd0);
`endif
      if (k > 0) checkOutput("dual_spacing", ack_log[k].cyc - ack_log[k-1].cyc, 32'd3);
    end
    repeat (2) begin @(negedge clk); #1; end
    checkOutput("dual_q0_left", q0.size(), 32'd0);
    checkOutput("dual_q1_left", q1.size(), 32'd0);

    $display("[TB] rejected accesses and sub-word loads");
    applyStimulus(1, 1'b1, 3'b010, 32'h0001_0011, 32'hCAFE_BABE, 1'b1, 32'h0, 0, "p1_sh_odd");
    checkOutput("mem_after_bad_sh", memWord(12'h010), 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 3'b111, 32'h0001_0010, 32'h0, 1'b1, 32'h0, 0, "p0_bad_mode");
    applyStimulus(0, 1'b0, 3'b001, 32'h0001_0012, 32'h0, 1'b1, 32'h0, 0, "p0_lw_misal");
    applyStimulus(0, 1'b0, 3'b011, 32'h0001_0013, 32'h0, 1'b0, 32'hFFFF_FFDE, 0, "p0_lb");
    applyStimulus(0, 1'b0, 3'b101, 32'h0001_0013, 32'h0, 1'b0, 32'h0000_00DE, 0, "p0_lbu");
    applyStimulus(0, 1'b0, 3'b010, 32'h0001_0012, 32'h0, 1'b0, 32'hFFFF_DEAD, 0, "p0_lh");
    applyStimulus(1, 1'b0, 3'b100, 32'h0001_0012, 32'h0, 1'b0, 32'h0000_DEAD, 0, "p1_lhu");
    applyStimulus(0, 1'b1, 3'b011, 32'h0001_0010, 32'h0000_0077, 1'b0, 32'h0, 1, "p0_sb");
    applyStimulus(0, 1'b0, 3'b001, 32'h0001_0010, 32'h0, 1'b0, 32'hDEAD_BE77, 0, "p0_lw_after_sb");

    $display("[TB] reset during ISSUE of a store");
    applyStimulus(0, 1'b1, 3'b001, 32'h0001_0020, 32'hA5A5_A5A5, 1'b0, 32'h0, 1, "p0_pre_store");
    n0 = ack_cnt0;
    p0_we = 1'b1; p0_mode = 3'b001; p0_addr = 32'h0001_0020; p0_wdata = 32'h1234_5678;
    p0_req = 1'b1;
    @(negedge clk); #1;
    checkOutput("abort_we_before", {31'b0, mem_WE}, 32'h1);
    checkOutput("abort_busy_before", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_we_after", {31'b0, mem_WE}, 32'h0);
    checkAllZero("abort");
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      checkAllZero("post_reset");
    end
    checkOutput("abort_no_ack", ack_cnt0 - n0, 32'd0);
    checkOutput("abort_mem_kept", memWord(12'h020), 32'hA5A5_A5A5);
    applyStimulus(0, 1'b0, 3'b001, 32'h0001_0020, 32'h0, 1'b0, 32'hA5A5_A5A5, 0, "p0_lw_after_abort");

    $display("[TB] port 0 holds req across its ack");
    e.err = 1'b0; e.rdata = 32'h1111_2222;
    q0.push_back(e);
    q0.push_back(e);
    p0_we = 1'b0; p0_mode = 3'b001; p0_addr = 32'h0001_0040;
    n0 = ack_cnt0;
    first = -1;
    second = -1;
    p0_req = 1'b1;
    start = cyc;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (ack_cnt0 == n0 + 1 && first < 0) first = cyc;
      if (ack_cnt0 == n0 + 2) begin
        second = cyc;
        break;
      end
    end
    p0_req = 1'b0;
    checkOutput("hold_first_latency", first - start, 32'd2);
    checkOutput("hold_gap", second - first, 32'd3);
    repeat (3) begin @(negedge clk); #1; end
    checkOutput("hold_q0_left", q0.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
